// File: rtl/axistream_unpack_keep_if.sv
// Stream bundle for the keep-aware unpacker: a wide packed source beat on one side
// and a word-serial destination on the other. The design under use takes the slave side.
interface axistream_unpack_keep_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter int IDX_W      = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1
) ();

  logic                           src_tvalid;
  logic                           src_tready;
  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata;
  logic [NUM_PACK-1:0]            src_tkeep;
  logic                           src_tlast;

  logic                           dest_tvalid;
  logic                           dest_tready;
  logic [DATA_WIDTH-1:0]          dest_tdata;
  logic                           dest_tlast;
  logic [IDX_W-1:0]               dest_tindex;

  logic                           tlast_dropped;

  // Environment side: produces source beats, consumes destination words.
  modport master (
    output src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
    input  src_tready, dest_tvalid, dest_tdata, dest_tlast, dest_tindex, tlast_dropped
  );

  // Unpacker side.
  modport slave (
    input  src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
    output src_tready, dest_tvalid, dest_tdata, dest_tlast, dest_tindex, tlast_dropped
  );

endinterface

// File: rtl/axistream_unpack_keep.sv
// Splits each NUM_PACK-word source beat into single-word beats, skipping words whose keep bit is clear.
// One cycle from accepted beat to first word; next beat loads alongside the last word; dest stall holds outputs and blocks src.
module axistream_unpack_keep #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int IDX_W      = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  axistream_unpack_keep_if.slave bus
);

  logic [DATA_WIDTH*NUM_PACK-1:0] data_q, data_d;
  logic                           tlast_q, tlast_d;
  logic [NUM_PACK-1:0]            rem_q, rem_d;
  logic                           drop_q, drop_d;

  logic [IDX_W-1:0]               sel;
  logic                           occupied;
  logic                           last_word;
  logic                           dest_hs;
  logic                           src_hs;
  logic                           src_null;

  // Priority pick over the remaining-word mask; later loop hits win.
  always_comb begin
    sel = '0;
    if (BIG_ENDIAN != 0) begin
      for (int i = 0; i < NUM_PACK; i++) begin
        if (rem_q[i]) sel = IDX_W'(i);
      end
    end else begin
      for (int i = NUM_PACK - 1; i >= 0; i--) begin
        if (rem_q[i]) sel = IDX_W'(i);
      end
    end
  end

  always_comb begin
    bus.dest_tdata = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (sel == IDX_W'(i)) bus.dest_tdata = data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign occupied  = (rem_q != '0);
  assign last_word = occupied && ((rem_q & (rem_q - NUM_PACK'(1))) == '0);

  assign bus.dest_tvalid   = !rst && occupied;
  assign bus.dest_tindex   = sel;
  assign bus.dest_tlast    = bus.dest_tvalid && last_word && tlast_q;
  assign bus.tlast_dropped = drop_q;

  assign dest_hs  = bus.dest_tvalid && bus.dest_tready;
  // Accept a new beat either into an empty buffer or in the cycle its last word leaves.
  assign bus.src_tready = !rst && (!occupied || (dest_hs && last_word));
  assign src_hs   = bus.src_tvalid && bus.src_tready;
  assign src_null = src_hs && (bus.src_tkeep == '0);

  always_comb begin
    rem_d   = rem_q;
    data_d  = data_q;
    tlast_d = tlast_q;
    drop_d  = src_null && bus.src_tlast;
    if (dest_hs) begin
      for (int i = 0; i < NUM_PACK; i++) begin
        if (sel == IDX_W'(i)) rem_d[i] = 1'b0;
      end
    end
    // A fresh beat overrides the bit-clear of the word leaving in the same cycle.
    if (src_hs && !src_null) begin
      rem_d   = bus.src_tkeep;
      data_d  = bus.src_tdata;
      tlast_d = bus.src_tlast;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      drop_q <= drop_d;
    end
  end

  // Payload is qualified by rem_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    tlast_q <= tlast_d;
  end

endmodule

// File: tb/tb_axistream_unpack_keep.sv
// Directed bench for axistream_unpack_keep: one little-endian and one big-endian instance
// with NUM_PACK=4, DATA_WIDTH=8 and hand-computed expected words.
module tb_axistream_unpack_keep;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axistream_unpack_keep_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .IDX_W(IW)) le_if ();
  axistream_unpack_keep_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .IDX_W(IW)) be_if ();

  axistream_unpack_keep #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(0), .IDX_W(IW)) u_le (
    .clk (clk),
    .rst (rst),
    .bus (le_if)
  );

  axistream_unpack_keep #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1), .IDX_W(IW)) u_be (
    .clk (clk),
    .rst (rst),
    .bus (be_if)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic src_beat(input bit be, input logic [31:0] data, input logic [3:0] keep, input logic last);
    if (be) begin
      be_if.src_tvalid = 1'b1; be_if.src_tdata = data; be_if.src_tkeep = keep; be_if.src_tlast = last;
    end else begin
      le_if.src_tvalid = 1'b1; le_if.src_tdata = data; le_if.src_tkeep = keep; le_if.src_tlast = last;
    end
  endtask

  task automatic src_idle();
    le_if.src_tvalid = 1'b0;
    be_if.src_tvalid = 1'b0;
  endtask

  // Checks the presented word at the current sample point.
  task automatic chk_word(input bit be, input string tag, input logic [7:0] data,
                          input logic [1:0] idx, input logic last);
    if (be) begin
      check({tag, ".vld"},  32'(be_if.dest_tvalid), 32'd1);
      check({tag, ".dat"},  32'(be_if.dest_tdata),  32'(data));
      check({tag, ".idx"},  32'(be_if.dest_tindex), 32'(idx));
      check({tag, ".last"}, 32'(be_if.dest_tlast),  32'(last));
    end else begin
      check({tag, ".vld"},  32'(le_if.dest_tvalid), 32'd1);
      check({tag, ".dat"},  32'(le_if.dest_tdata),  32'(data));
      check({tag, ".idx"},  32'(le_if.dest_tindex), 32'(idx));
      check({tag, ".last"}, 32'(le_if.dest_tlast),  32'(last));
    end
  endtask

  // Streams two full-keep beats back to back and checks order, tlast and stall stability.
  task automatic run_b2b(input bit stall);
    logic [31:0] beats [2];
    int          beat;
    int          got;
    int          cyc;
    int          first_cyc;
    int          last_cyc;
    bit          src_acc;
    bit          prev_stall;
    logic [7:0]  prev_data;
    beats[0]   = 32'h44332211;
    beats[1]   = 32'h88776655;
    beat       = 0;
    got        = 0;
    cyc        = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    src_beat(1'b0, beats[0], 4'b1111, 1'b0);
    while (got < 8 && cyc < 200) begin
      le_if.dest_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        check("b2b.hold_vld", 32'(le_if.dest_tvalid), 32'd1);
        check("b2b.hold_dat", 32'(le_if.dest_tdata),  32'(prev_data));
      end
      if (le_if.dest_tvalid && le_if.dest_tready) begin
        check("b2b.dat",  32'(le_if.dest_tdata), 32'((got + 1) * 32'h11));
        check("b2b.last", 32'(le_if.dest_tlast), 32'(got == 7));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      prev_stall = le_if.dest_tvalid && !le_if.dest_tready;
      prev_data  = le_if.dest_tdata;
      src_acc    = le_if.src_tvalid && le_if.src_tready;
      next_cycle();
      cyc++;
      if (src_acc) begin
        beat++;
        if (beat < 2) src_beat(1'b0, beats[beat], 4'b1111, 1'b1);
        else          le_if.src_tvalid = 1'b0;
      end
    end
    le_if.dest_tready = 1'b1;
    src_idle();
    check("b2b.count", 32'(got), 32'd8);
    if (!stall) check("b2b.cycles", 32'(last_cyc - first_cyc + 1), 32'd8);
    @(negedge clk);
    check("b2b.drained", 32'(le_if.dest_tvalid), 32'd0);
    next_cycle();
  endtask

  initial begin
    le_if.src_tvalid = 1'b0; le_if.src_tdata = '0; le_if.src_tkeep = '0; le_if.src_tlast = 1'b0;
    be_if.src_tvalid = 1'b0; be_if.src_tdata = '0; be_if.src_tkeep = '0; be_if.src_tlast = 1'b0;
    le_if.dest_tready = 1'b1;
    be_if.dest_tready = 1'b1;

    // Reset state
    #3;
    check("rst.dvld", 32'(le_if.dest_tvalid),   32'd0);
    check("rst.srdy", 32'(le_if.src_tready),    32'd0);
    check("rst.drop", 32'(le_if.tlast_dropped), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Full keep, little endian
    src_beat(1'b0, 32'h44332211, 4'b1111, 1'b1);
    @(negedge clk);
    check("full.srdy_empty", 32'(le_if.src_tready),  32'd1);
    check("full.dvld_empty", 32'(le_if.dest_tvalid), 32'd0);
    next_cycle();
    src_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_word(1'b0, "full", 8'((i + 1) * 8'h11), 2'(i), i == 3);
      check("full.srdy", 32'(le_if.src_tready), 32'(i == 3));
      next_cycle();
    end
    @(negedge clk);
    check("full.idle", 32'(le_if.dest_tvalid), 32'd0);
    next_cycle();

    // Sparse keep 0101
    src_beat(1'b0, 32'hDDCCBBAA, 4'b0101, 1'b1);
    next_cycle();
    src_idle();
    @(negedge clk);
    chk_word(1'b0, "sparse0", 8'hAA, 2'd0, 1'b0);
    check("sparse0.srdy", 32'(le_if.src_tready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_word(1'b0, "sparse1", 8'hCC, 2'd2, 1'b1);
    check("sparse1.srdy", 32'(le_if.src_tready), 32'd1);
    next_cycle();
    @(negedge clk);
    check("sparse.idle", 32'(le_if.dest_tvalid), 32'd0);
    next_cycle();

    // Big endian, keep 0011, no tlast
    src_beat(1'b1, 32'hDDCCBBAA, 4'b0011, 1'b0);
    next_cycle();
    src_idle();
    @(negedge clk);
    chk_word(1'b1, "be0", 8'hBB, 2'd1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_word(1'b1, "be1", 8'hAA, 2'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    check("be.idle", 32'(be_if.dest_tvalid), 32'd0);
    next_cycle();

    // Back to back, first with ready held high, then with random stalls
    run_b2b(1'b0);
    run_b2b(1'b1);

    // Null beat carrying tlast
    src_beat(1'b0, 32'h12345678, 4'b0000, 1'b1);
    @(negedge clk);
    check("null.srdy", 32'(le_if.src_tready), 32'd1);
    next_cycle();
    src_idle();
    @(negedge clk);
    check("null.dvld", 32'(le_if.dest_tvalid),   32'd0);
    check("null.drop", 32'(le_if.tlast_dropped), 32'd1);
    next_cycle();
    @(negedge clk);
    check("null.drop_clr", 32'(le_if.tlast_dropped), 32'd0);
    check("null.dvld2",    32'(le_if.dest_tvalid),   32'd0);
    next_cycle();

    // Asynchronous reset after two of four words
    src_beat(1'b0, 32'h44332211, 4'b1111, 1'b0);
    next_cycle();
    src_idle();
    @(negedge clk);
    chk_word(1'b0, "arst0", 8'h11, 2'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_word(1'b0, "arst1", 8'h22, 2'd1, 1'b0);
    next_cycle();
    check("arst.pre_vld", 32'(le_if.dest_tvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst.dvld", 32'(le_if.dest_tvalid), 32'd0);
    check("arst.srdy", 32'(le_if.src_tready),  32'd0);
    next_cycle();
    rst = 1'b0;
    src_beat(1'b0, 32'h0000BEEF, 4'b0001, 1'b0);
    @(negedge clk);
    check("arst.srdy_rel", 32'(le_if.src_tready), 32'd1);
    next_cycle();
    src_idle();
    @(negedge clk);
    chk_word(1'b0, "arst_ef", 8'hEF, 2'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    check("arst.idle", 32'(le_if.dest_tvalid), 32'd0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axistream_unpack_keep.md
Name: axistream_unpack_keep

Overview:
- Parametrised successor to the fixed-count unpacker: splits each NUM_PACK-word source beat into single-word destination beats, emitting only words whose src_tkeep bit is set.
- Sits between wide packed datapaths (DMA, width converters) and narrow word-serial consumers; handles partial and null beats at packet ends.
- Zero-bubble: the next source beat loads in the same cycle as the last word of the current beat.

Parameters:
- DATA_WIDTH, 8, width of one output word; must be >= 1.
- NUM_PACK, 4, words per source beat; must be >= 2.
- BIG_ENDIAN, 0, word order: 0 emits word 0 (src_tdata[DATA_WIDTH-1:0]) first; 1 emits word NUM_PACK-1 first.
- IDX_W, max(1,$clog2(NUM_PACK)), width of dest_tindex (derived; not for override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_tvalid  in  1  source beat valid.
- src_tready  out  1  source beat accepted when src_tvalid && src_tready.
- src_tdata  in  DATA_WIDTH*NUM_PACK  packed words; word i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- src_tkeep  in  NUM_PACK  bit i set = word i is valid.
- src_tlast  in  1  beat ends a packet.
- dest_tvalid  out  1  output word valid.
- dest_tready  in  1  downstream ready.
- dest_tdata  out  DATA_WIDTH  current word.
- dest_tlast  out  1  last kept word of a src_tlast beat.
- dest_tindex  out  IDX_W  word position i of dest_tdata within its source beat.
- tlast_dropped  out  1  one-cycle pulse: an all-zero-keep beat carrying tlast was consumed.

Behaviour:
- State: data_buf, tlast_buf, rem_mask[NUM_PACK-1:0] (kept words not yet sent). Buffer is "occupied" iff rem_mask != 0.
- Reset (async, immediate): rem_mask=0, tlast_dropped=0. dest_tvalid, dest_tlast and src_tready are 0 while rst is high (gated combinationally by rst). data_buf and tlast_buf are not reset.
- dest_tvalid = !rst && rem_mask != 0.
- Selection: BIG_ENDIAN=0 uses the lowest set bit of rem_mask; BIG_ENDIAN=1 uses the highest. dest_tdata is word[sel]; dest_tindex = sel.
- last_word = rem_mask has exactly one bit set. dest_tlast = dest_tvalid && last_word && tlast_buf.
- On dest handshake: clear bit sel in rem_mask.
- src_tready = !rst && (rem_mask == 0 || (dest_tvalid && dest_tready && last_word)).
- On src handshake with src_tkeep != 0: load data_buf, tlast_buf and rem_mask = src_tkeep. This overrides the bit-clear in the same cycle.
- On src handshake with src_tkeep == 0: the beat is consumed and nothing is loaded. tlast_dropped = src_tlast on the next cycle, otherwise 0.
- Latency: accepted beat to first dest_tvalid is 1 cycle.
- Throughput: one word per cycle with dest_tready held high. For full-keep beats, src_tready pulses once every NUM_PACK cycles.
- Backpressure: while dest_tvalid && !dest_tready, dest_tdata, dest_tindex and dest_tlast hold stable.
- Keep holes, e.g. 0101, are skipped with no idle cycle. Non-contiguous keep is legal.
- Reset mid-beat: remaining words are discarded. After release, the first accepted beat starts from its first kept word.
- src_tvalid low while occupied has no effect. src_tdata is not sampled outside a handshake.

Test Plan:
- Full keep: NUM_PACK=4, BIG_ENDIAN=0, data 0x44332211, keep 1111, tlast=1, dest_tready=1 -> 11,22,33,44 on consecutive cycles; indices 0..3; dest_tlast only on 44.
- Sparse keep: data 0xDDCCBBAA, keep 0101, tlast=1 -> AA (idx 0, tlast 0), then CC (idx 2, tlast 1); src_tready high in the CC cycle.
- BIG_ENDIAN=1: data 0xDDCCBBAA, keep 0011, tlast=0 -> BB (idx 1), then AA (idx 0); dest_tlast never set.
- Back-to-back with random dest_tready stalls: beats 0x44332211 and 0x88776655, full keep -> exactly 11..88 in order, no duplicates; with ready=1, 8 words in 8 cycles.
- Null beat: keep 0000, tlast=1 while empty -> accepted immediately, no dest_tvalid, tlast_dropped high for exactly 1 cycle.
- Async reset: assert rst after 2 of 4 words with no clock edge -> dest_tvalid and src_tready fall immediately. After release, beat 0x0000BEEF keep 0001 -> single word EF with idx 0.
